// File: rtl/product_accum.sv
// Partial-product accumulator: sums NUM_PARTIALS shifted partials per multiply.
// Optional sticky carry-out flag on ovf is built only when ACC_OVF_CHECK_EN is defined.
module product_accum #(
    parameter int NUM_PARTIALS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] acc_in,
    input  logic        acc_valid,
    output logic [15:0] product,
    output logic        busy,
    output logic        done,
    output logic [2:0]  count,
    output logic        ovf
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [3:0] LAST_CNT = 4'(NUM_PARTIALS);

    logic [1:0]  state_q, state_d;
    logic [15:0] sum_q, sum_d;
    // One bit wider than the port so the terminal compare works for NUM_PARTIALS=8.
    logic [3:0]  cnt_q, cnt_d;
    logic [16:0] add_full;
    logic [3:0]  cnt_inc;
    logic        accept;

    assign add_full = {1'b0, sum_q} + {1'b0, acc_in};
    assign cnt_inc  = cnt_q + 4'd1;
    assign accept   = (state_q == ST_ACCUM) && acc_valid && !start;

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        if (start) begin
            state_d = ST_ACCUM;
            sum_d   = 16'h0000;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (acc_valid) begin
                        sum_d = add_full[15:0];
                        cnt_d = cnt_inc;
                        if (cnt_inc == LAST_CNT) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sum_q   <= 16'h0000;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef ACC_OVF_CHECK_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (start) begin
            ovf_d = 1'b0;
        end else if (accept && add_full[16]) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_accept;
    assign unused_accept = accept ^ add_full[16];
    assign ovf = 1'b0;
`endif

    assign product = sum_q;
    assign count   = cnt_q[2:0];
    assign busy    = (state_q == ST_ACCUM);
    assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_product_accum.sv
// Directed-vector bench for product_accum with hand-computed expected sums.
module tb_product_accum;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] acc_in = 16'h0000;
    logic        acc_valid = 1'b0;
    logic [15:0] product;
    logic        busy;
    logic        done;
    logic [2:0]  count;
    logic        ovf;

    int vectors = 0;
    int miscompares = 0;
    logic exp_ovf;

    product_accum #(.NUM_PARTIALS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .acc_in    (acc_in),
        .acc_valid (acc_valid),
        .product   (product),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [15:0] v);
        acc_in = v;
        acc_valid = 1'b1;
        tick();
        acc_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #1;
        // Reset state
        reset = 1'b1;
        start = 1'b1;
        acc_valid = 1'b1;
        acc_in = 16'hAAAA;
        tick();
        reset = 1'b0;
        start = 1'b0;
        acc_valid = 1'b0;
        check_vec("rst_product", 32'(product), 32'h0000);
        check_vec("rst_count", 32'(count), 32'd0);
        check_vec("rst_busy", 32'(busy), 32'd0);
        check_vec("rst_done", 32'(done), 32'd0);
        check_vec("rst_ovf", 32'(ovf), 32'd0);

        // 0xFF * 0xFF, back-to-back partials
        do_start();
        check_vec("t1_busy", 32'(busy), 32'd1);
        check_vec("t1_count0", 32'(count), 32'd0);
        feed(16'h00E1);
        check_vec("t1_p1", 32'(product), 32'h00E1);
        feed(16'h0E10);
        feed(16'h0E10);
        check_vec("t1_p3", 32'(product), 32'h1D01);
        check_vec("t1_done_early", 32'(done), 32'd0);
        feed(16'hE100);
        check_vec("t1_done", 32'(done), 32'd1);
        check_vec("t1_busy_off", 32'(busy), 32'd0);
        check_vec("t1_product", 32'(product), 32'hFE01);
        check_vec("t1_count", 32'(count), 32'd4);
        check_vec("t1_ovf", 32'(ovf), 32'd0);
        tick();
        check_vec("t1_done_once", 32'(done), 32'd0);
        check_vec("t1_hold", 32'(product), 32'hFE01);
        check_vec("t1_hold_cnt", 32'(count), 32'd4);

        // Same partials with a 3-cycle valid gap
        do_start();
        check_vec("t2_clear", 32'(product), 32'h0000);
        feed(16'h00E1);
        feed(16'h0E10);
        for (int i = 0; i < 3; i++) begin
            acc_in = 16'hFFFF;
            tick();
            check_vec("t2_gap_busy", 32'(busy), 32'd1);
            check_vec("t2_gap_prod", 32'(product), 32'h0EF1);
        end
        feed(16'h0E10);
        feed(16'hE100);
        check_vec("t2_done", 32'(done), 32'd1);
        check_vec("t2_product", 32'(product), 32'hFE01);
        tick();

        // Restart after two partials; coincident acc_valid is dropped
        do_start();
        feed(16'h00E1);
        feed(16'h0E10);
        check_vec("t3_mid", 32'(product), 32'h0EF1);
        check_vec("t3_mid_cnt", 32'(count), 32'd2);
        start = 1'b1;
        acc_valid = 1'b1;
        acc_in = 16'h0100;
        tick();
        start = 1'b0;
        acc_valid = 1'b0;
        check_vec("t3_restart_p", 32'(product), 32'h0000);
        check_vec("t3_restart_c", 32'(count), 32'd0);
        check_vec("t3_restart_b", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) feed(16'h0001);
        check_vec("t3_done", 32'(done), 32'd1);
        check_vec("t3_product", 32'(product), 32'h0004);
        tick();

        // Reset mid-ACCUM with count=3
        do_start();
        feed(16'h0010);
        feed(16'h0020);
        feed(16'h0030);
        check_vec("t4_cnt3", 32'(count), 32'd3);
        reset = 1'b1;
        acc_valid = 1'b1;
        acc_in = 16'h0040;
        tick();
        reset = 1'b0;
        check_vec("t4_busy", 32'(busy), 32'd0);
        check_vec("t4_product", 32'(product), 32'h0000);
        check_vec("t4_count", 32'(count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            acc_in = 16'h0005;
            tick();
            check_vec("t4_no_done", 32'(done), 32'd0);
            check_vec("t4_idle_prod", 32'(product), 32'h0000);
        end
        acc_valid = 1'b0;

        // Reset wins over start in ACCUM
        do_start();
        feed(16'h0007);
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check_vec("t5_rst_busy", 32'(busy), 32'd0);
        check_vec("t5_rst_prod", 32'(product), 32'h0000);

        // Carry out of bit 15
`ifdef ACC_OVF_CHECK_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        do_start();
        feed(16'hFFFF);
        feed(16'h0002);
        feed(16'h0000);
        feed(16'h0000);
        check_vec("t6_done", 32'(done), 32'd1);
        check_vec("t6_product", 32'(product), 32'h0001);
        check_vec("t6_ovf", 32'(ovf), 32'(exp_ovf));
        tick();
        check_vec("t6_ovf_hold", 32'(ovf), 32'(exp_ovf));

        // start with acc_valid in IDLE
        start = 1'b1;
        acc_valid = 1'b1;
        acc_in = 16'h1234;
        tick();
        start = 1'b0;
        acc_valid = 1'b0;
        check_vec("t7_product", 32'(product), 32'h0000);
        check_vec("t7_count", 32'(count), 32'd0);
        check_vec("t7_busy", 32'(busy), 32'd1);
        check_vec("t7_ovf_clr", 32'(ovf), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
